// File: rtl/datapath_mc_if.sv
// datapath_mc_if: instruction handshake, memory port, flags and debug
// read bundle between the control unit / memory and datapath_mc.
interface datapath_mc_if #(
  parameter int NBIT = 16,
  parameter int AW   = 3
);
  logic            valid_in;
  logic            ready;
  logic [AW-1:0]   DR;
  logic [AW-1:0]   SA;
  logic [AW-1:0]   SB;
  logic [3:0]      FS;
  logic            MB;
  logic            MD;
  logic            MW;
  logic            RW;
  logic [NBIT-1:0] const_in;
  logic            mem_req;
  logic            mem_we;
  logic [NBIT-1:0] mem_addr;
  logic [NBIT-1:0] mem_wdata;
  logic [NBIT-1:0] mem_rdata;
  logic            mem_ack;
  logic            done;
  logic            V;
  logic            C;
  logic            N;
  logic            Z;
  logic            err;
  logic [AW-1:0]   dbg_sel;
  logic [NBIT-1:0] dbg_data;

  modport master (
    output valid_in, DR, SA, SB, FS, MB, MD, MW, RW, const_in,
    output mem_rdata, mem_ack, dbg_sel,
    input  ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  done, V, C, N, Z, err, dbg_data
  );

  modport slave (
    input  valid_in, DR, SA, SB, FS, MB, MD, MW, RW, const_in,
    input  mem_rdata, mem_ack, dbg_sel,
    output ready, mem_req, mem_we, mem_addr, mem_wdata,
    output done, V, C, N, Z, err, dbg_data
  );
endinterface

// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle register-file datapath with function unit,
// registered flags and req/ack memory port. MEM_TIMEOUT_EN adds mem wait limit.
module datapath_mc #(
  parameter int NBIT    = 16,
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input logic           clk_main,
  input logic           reset,
  datapath_mc_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;

  logic [1:0]      state_q;
  logic [AW-1:0]   dr_q, sa_q, sb_q;
  logic [3:0]      fs_q;
  logic            mb_q, md_q, mw_q, rw_q;
  logic [NBIT-1:0] k_q;
  logic [NBIT-1:0] rf_q [NREG];
  logic [3:0]      flg_q;
  logic            req_q, we_q, done_q, err_q;
  logic [NBIT-1:0] addr_q, wdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q;
`endif

  logic [NBIT-1:0] a_w, b_w, bop, f_w;
  logic [NBIT:0]   sum;
  logic            cin, c_w, v_w;

  // function unit: adder ops at NBIT+1 for carry, others decoded on FS[2:0]
  always_comb begin
    a_w = rf_q[sa_q];
    b_w = mb_q ? k_q : rf_q[sb_q];
    bop = '0;
    cin = 1'b0;
    unique case (fs_q)
      4'b0001: cin = 1'b1;
      4'b0010: bop = b_w;
      4'b0011: begin bop = b_w; cin = 1'b1; end
      4'b0100: bop = ~b_w;
      4'b0101: begin bop = ~b_w; cin = 1'b1; end
      4'b0110: bop = '1;
      default: ;
    endcase
    sum = {1'b0, a_w} + {1'b0, bop} + {{NBIT{1'b0}}, cin};
    f_w = sum[NBIT-1:0];
    c_w = sum[NBIT];
    v_w = (a_w[NBIT-1] == bop[NBIT-1]) &&
          (sum[NBIT-1] != a_w[NBIT-1]);
    if (fs_q[3]) begin
      c_w = 1'b0;
      v_w = 1'b0;
      unique case (fs_q[2:0])
        3'b000: f_w = a_w & b_w;
        3'b001: f_w = a_w | b_w;
        3'b010: f_w = a_w ^ b_w;
        3'b011: f_w = ~a_w;
        3'b101: begin
          f_w = {1'b0, b_w[NBIT-1:1]};
          c_w = b_w[0];
        end
        3'b110: begin
          f_w = {b_w[NBIT-2:0], 1'b0};
          c_w = b_w[NBIT-1];
        end
        default: f_w = b_w;
      endcase
    end
  end

  // FSM, instruction latch, flags, memory port and register file
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dr_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      fs_q    <= '0;
      mb_q    <= 1'b0;
      md_q    <= 1'b0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      k_q     <= '0;
      flg_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.valid_in) begin
            dr_q    <= bus.DR;
            sa_q    <= bus.SA;
            sb_q    <= bus.SB;
            fs_q    <= bus.FS;
            mb_q    <= bus.MB;
            md_q    <= bus.MD;
            mw_q    <= bus.MW;
            rw_q    <= bus.RW;
            k_q     <= bus.const_in;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          flg_q <= {v_w, c_w, f_w[NBIT-1], f_w == '0};
          if (mw_q || md_q) begin
            addr_q  <= a_w;
            wdata_q <= b_w;
            we_q    <= mw_q;
            req_q   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            state_q <= S_MEM;
          end else begin
            if (rw_q) rf_q[dr_q] <= f_w;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            req_q <= 1'b0;
            if (!mw_q && rw_q) rf_q[dr_q] <= bus.mem_rdata;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = done_q;
  assign bus.V         = flg_q[3];
  assign bus.C         = flg_q[2];
  assign bus.N         = flg_q[1];
  assign bus.Z         = flg_q[0];
  assign bus.dbg_data  = rf_q[bus.dbg_sel];
`ifdef MEM_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed steps with an expected-result queue popped
// at each retire pulse of datapath_mc.
module tb_datapath_mc;
  localparam int NBIT = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int TO   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datapath_mc_if #(.NBIT(NBIT), .AW(AW)) bus ();

  datapath_mc #(
    .NBIT(NBIT), .NREG(NREG), .AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk_main(clk),
    .reset   (rst),
    .bus     (bus)
  );

  typedef struct {
    string           tag;
    logic [AW-1:0]   dr;
    logic [NBIT-1:0] val;
    logic [3:0]      vcnz;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [AW-1:0] dr,
                      input logic [NBIT-1:0] val, input logic [3:0] f);
    exp_t e;
    e.tag  = tag;
    e.dr   = dr;
    e.val  = val;
    e.vcnz = f;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [AW-1:0] dr, input logic [AW-1:0] sa,
                       input logic [AW-1:0] sb, input logic [3:0] fs,
                       input logic mb, input logic md, input logic mw,
                       input logic rw, input logic [NBIT-1:0] k);
    int ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("ready_wait", ok, 1);
    bus.DR = dr; bus.SA = sa; bus.SB = sb; bus.FS = fs;
    bus.MB = mb; bus.MD = md; bus.MW = mw; bus.RW = rw;
    bus.const_in = k;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
  endtask

  task automatic retire(input int exp_lat);
    int lat;
    exp_t e;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin lat = i; break; end
    end
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    else chk("done_seen", (lat > 0) ? 1 : 0, 1);
    chk("ready_at_done", bus.ready, 1);
    chk("sb_nonempty", (sbq.size() > 0) ? 1 : 0, 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.dbg_sel = e.dr;
      #1;
      chk({e.tag, "_reg"}, bus.dbg_data, e.val);
      chk({e.tag, "_vcnz"}, {bus.V, bus.C, bus.N, bus.Z}, e.vcnz);
    end
  endtask

  task automatic op(input string tag, input logic [AW-1:0] dr,
                    input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                    input logic [3:0] fs, input logic mb, input logic rw,
                    input logic [NBIT-1:0] k, input logic [NBIT-1:0] ev,
                    input logic [3:0] ef);
    push(tag, dr, ev, ef);
    issue(dr, sa, sb, fs, mb, 1'b0, 1'b0, rw, k);
    retire(2);
  endtask

  initial begin
    int reqc;
    bus.valid_in = 0; bus.DR = 0; bus.SA = 0; bus.SB = 0; bus.FS = 0;
    bus.MB = 0; bus.MD = 0; bus.MW = 0; bus.RW = 0; bus.const_in = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0; bus.dbg_sel = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_vcnz", {bus.V, bus.C, bus.N, bus.Z}, 0);
    @(negedge clk);
    rst = 1'b0;

    op("r1_const", 1, 0, 0, 4'hC, 1, 1, 16'h7FFF, 16'h7FFF, 4'b0000);
    op("inc_ovf",  2, 1, 0, 4'h1, 0, 1, 16'h0000, 16'h8000, 4'b1010);
    op("r3_const", 3, 0, 0, 4'hC, 1, 1, 16'hFFFF, 16'hFFFF, 4'b0010);
    op("inc_wrap", 4, 3, 0, 4'h1, 0, 1, 16'h0000, 16'h0000, 4'b0101);
    op("r5_const", 5, 0, 0, 4'hC, 1, 1, 16'h0005, 16'h0005, 4'b0000);
    op("r6_const", 6, 0, 0, 4'hC, 1, 1, 16'h0005, 16'h0005, 4'b0000);
    op("sub_nowr", 7, 5, 6, 4'h5, 0, 0, 16'h0000, 16'h0000, 4'b0101);
    bus.dbg_sel = 5; #1 chk("r5_kept", bus.dbg_data, 16'h0005);
    op("a_notb",   0, 5, 6, 4'h4, 0, 1, 16'h0000, 16'hFFFF, 4'b0010);
    op("dec_zero", 0, 7, 0, 4'h6, 0, 1, 16'h0000, 16'hFFFF, 4'b0010);
    op("shr",      0, 0, 0, 4'hD, 1, 1, 16'h0003, 16'h0001, 4'b0100);
    op("shl",      0, 0, 0, 4'hE, 1, 1, 16'h8001, 16'h0002, 4'b0100);
    op("xor",      0, 1, 2, 4'hA, 0, 1, 16'h0000, 16'hFFFF, 4'b0010);

    push("load", 7, 16'h1234, 4'b0000);
    issue(7, 1, 0, 4'h0, 0, 1, 0, 1, 16'h0000);
    reqc = 0;
    for (int i = 0; i < 20 && reqc < 3; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        reqc++;
        chk("ld_addr", bus.mem_addr, 16'h7FFF);
        chk("ld_we", bus.mem_we, 0);
      end
    end
    chk("ld_req_cycles", reqc, 3);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h1234;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;
    retire(0);
    chk("ld_req_drop", bus.mem_req, 0);

    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    @(negedge clk);
    chk("idle_ack_done", bus.done, 0);
    chk("idle_ack_ready", bus.ready, 1);
    bus.mem_ack = 1'b0;
    bus.dbg_sel = 7; #1 chk("idle_ack_r7", bus.dbg_data, 16'h1234);

    issue(0, 1, 2, 4'h0, 0, 0, 1, 0, 16'h0000);
    reqc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin reqc = 1; break; end
    end
    chk("st_req", reqc, 1);
    chk("st_we", bus.mem_we, 1);
    chk("st_addr", bus.mem_addr, 16'h7FFF);
    chk("st_wdata", bus.mem_wdata, 16'h8000);
    repeat (2) @(negedge clk);
    chk("st_hold", bus.mem_req, 1);
    chk("st_err", bus.err, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", bus.mem_req, 0);
    chk("rst_mid_ready", bus.ready, 1);
    reqc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) reqc++;
    end
    chk("rst_mid_nodone", reqc, 0);
    for (int r = 0; r < NREG; r++) begin
      bus.dbg_sel = AW'(r);
      #1 chk("rst_mid_reg", bus.dbg_data, 16'h0000);
    end
    chk("rst_mid_vcnz", {bus.V, bus.C, bus.N, bus.Z}, 0);
    @(negedge clk);
    rst = 1'b0;
    reqc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) reqc++;
    end
    chk("post_rst_nodone", reqc, 0);

`ifdef MEM_TIMEOUT_EN
    op("r3_set", 3, 0, 0, 4'hC, 1, 1, 16'hABCD, 16'hABCD, 4'b0010);
    issue(3, 0, 0, 4'h0, 0, 1, 0, 1, 16'h0000);
    reqc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) reqc++;
      else if (reqc > 0) break;
    end
    chk("to_req_cycles", reqc, TO);
    chk("to_done", bus.done, 1);
    chk("to_err", bus.err, 1);
    bus.dbg_sel = 3; #1 chk("to_r3_kept", bus.dbg_data, 16'hABCD);
    @(negedge clk);
    chk("to_err_sticky", bus.err, 1);
`endif

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
Parametrised multi-cycle successor to the single-cycle datapath. It contains an NREG x NBIT register file, a Mano-style function unit with registered V/C/N/Z flags, B/D source muxes and a req/ack memory port. Instructions are accepted through a valid/ready handshake from the control unit. Memory accesses stall the block until the memory acknowledges.

Parameters:
NBIT, 16, data/register width (>=4)
NREG, 8, register count (power of 2)
AW, 3, register address width, log2(NREG)
TIMEOUT, 255, mem wait limit in cycles (MEM_TIMEOUT_EN only)

Ports:
clk_main  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
valid_in  input  1  instruction present
ready  output  1  block can accept; high only in IDLE
DR  input  AW  destination register
SA  input  AW  source A register
SB  input  AW  source B register
FS  input  4  function select
MB  input  1  B mux: 0=R[SB], 1=const_in
MD  input  1  D mux: 0=function unit, 1=mem_rdata
MW  input  1  memory write
RW  input  1  register write enable
const_in  input  NBIT  constant operand
mem_req  output  1  memory request
mem_we  output  1  1=write, 0=read
mem_addr  output  NBIT  = latched A operand
mem_wdata  output  NBIT  = latched B-mux operand
mem_rdata  input  NBIT  read data, valid with mem_ack
mem_ack  input  1  one-cycle completion strobe
done  output  1  one-cycle pulse at instruction retire
V, C, N, Z  output  1 each  registered status flags
err  output  1  sticky timeout flag (0 when feature absent)
dbg_sel  input  AW  debug read select
dbg_data  output  NBIT  combinational R[dbg_sel]

Behaviour:
- Reset: all registers 0; V=C=N=Z=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; done=0; err=0; state=IDLE, so ready=1.
- FSM states: IDLE, EXEC, MEM.
- IDLE: if valid_in, latch DR/SA/SB/FS/MB/MD/MW/RW/const_in and go to EXEC. Inputs are ignored while ready=0.
- EXEC: read A=R[SA] and B=mux(MB), then compute F. At the clock edge, flags update from F.
  - If MW=1 or MD=1: latch mem_addr=A, mem_wdata=B, mem_we=MW; set mem_req=1; go to MEM.
  - Otherwise: if RW=1, R[DR]<=F; pulse done; go to IDLE.
  - Latency: a non-memory op retires 2 cycles after acceptance.
- MEM: mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack: mem_req<=0; if read and RW=1, R[DR]<=mem_rdata; pulse done; go to IDLE.
  - An ack arriving in the same cycle mem_req first rises is not possible (req is registered). An ack seen outside MEM is ignored.
- MW=1 with MD=1: the write takes precedence and there is no register writeback.
- Memory operations leave the flags as computed in EXEC (F is still evaluated).
- FS encoding, with adder ops computed at NBIT+1 width:
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0011 A+B+1
  - 0100 A+~B
  - 0101 A+~B+1
  - 0110 A-1
  - 0111 A
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
  - 1100 B
  - 1101 B>>1 (logical)
  - 1110 B<<1
  - 1111 B
- Flags:
  - FS 0000-0111: C=carry out; V=signed overflow of the adder.
  - Logic ops and B transfer: C=0, V=0.
  - Shifts: C=bit shifted out, V=0.
  - N=F[NBIT-1]; Z=(F==0).
- Write in EXEC followed by a read in the next instruction's EXEC returns the new value. dbg_data reflects a write on the cycle after it.
- Reset asserted mid-MEM: mem_req drops immediately (async), the instruction is lost and no done pulse is generated.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: a counter runs in MEM. After TIMEOUT cycles with no ack, the block drops mem_req, sets sticky err=1, skips writeback, pulses done and returns to IDLE. err clears only on reset.
- Undefined: no counter, MEM waits indefinitely, err is tied 0.

Test Plan:
- Reset, then R1 via const path (MB=1, FS=1100, const=0x7FFF, DR=1) -> R1=0x7FFF; then FS=0001 SA=1 DR=2 -> R2=0x8000, V=1, N=1, C=0, Z=0; done 2 cycles after each accept.
- R3=0xFFFF, FS=0001 SA=3 DR=4 -> R4=0x0000, C=1, Z=1, V=0.
- R5=5, R6=5, FS=0101 SA=5 SB=6, RW=0 -> Z=1, C=1, no register changed.
- Load MD=1, DR=7, SA=1; ack delayed 3 cycles with mem_rdata=0x1234 -> mem_req high 3 cycles with addr 0x7FFF stable, R7=0x1234, ready returns after done.
- Store MW=1 SA=1 SB=2 -> mem_we=1, mem_wdata=0x8000; reset pulsed mid-wait -> mem_req=0 immediately, no done, all registers 0.
- MEM_TIMEOUT_EN with TIMEOUT=4: load never acked -> mem_req high 4 cycles, err=1, done pulse, destination register unchanged.
